io_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the SoC IO page (CPU address bit 22 set), alongside the LED register.
- Consumes CPU store strobes decoded by the SoC, buffers bytes in a small FIFO, and serialises them 8N1 on `tx`.
- Returns a status word to the CPU on IO reads, so firmware can poll before writing.

---
 rtl/io_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_io_uart_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the SoC IO page.
// The CPU pushes bytes into a small FIFO and polls a status word; the FSM drains the FIFO onto tx.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_sel,
  input  logic [29:0] io_wordaddr,
  input  logic [31:0] io_wdata,
  input  logic        io_wstrb,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [1:0]        state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_reg, tx_next;
  logic              busy_reg, busy_next;
  logic              overflow_reg;
  logic [31:0]       rdata_reg;

  logic wr_en, rd_en, fifo_full, fifo_empty, push, overflow_set, pop;
  logic [31:0] status;

  logic unused_bits;
  assign unused_bits = ^{io_wdata[31:8], io_wordaddr[29:3], io_wordaddr[0]};

  assign wr_en        = io_sel & io_wstrb & io_wordaddr[1];
  assign rd_en        = io_sel & io_rstrb & io_wordaddr[2];
  assign fifo_full    = (count_reg == CNT_FULL);
  assign fifo_empty   = (count_reg == '0);
  assign push         = wr_en & ~fifo_full;
  assign overflow_set = wr_en & fifo_full;

  // An overflow on the same edge as the read must be visible in the returned word.
  assign status = {28'd0, overflow_reg | overflow_set,
                   fifo_empty & (state_reg == S_IDLE), busy_reg, fifo_full};

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
          baud_next  = BAUD_LOAD;
          tx_next    = 1'b0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (baud_reg == '0) begin
          state_next   = S_DATA;
          bit_idx_next = 3'd0;
          baud_next    = BAUD_LOAD;
          tx_next      = shift_reg[0];
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_reg == '0) begin
          baud_next = BAUD_LOAD;
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
      default: begin
        // Stop bit: chain straight into the next frame when data is waiting.
        if (baud_reg == '0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            baud_next  = BAUD_LOAD;
            tx_next    = 1'b0;
            state_next = S_START;
          end else begin
            tx_next    = 1'b1;
            state_next = S_IDLE;
          end
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    busy_next = (count_next != '0) || (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= io_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= S_IDLE;
      baud_reg     <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg   <= count_next;
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end else if (rd_en) begin
        overflow_reg <= 1'b0;
      end
      if (rd_en) rdata_reg <= status;
    end
  end

  assign io_rdata = rdata_reg;
  assign tx       = tx_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomised scoreboard bench for io_uart_tx: a timeline model predicts frame start edges,
// status words and busy; a serial receiver and a read monitor compare against it.
module tb_io_uart_tx;
  localparam int C = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_sel = 1'b0;
  logic [29:0] io_wordaddr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_wstrb = 1'b0;
  logic        io_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic        tx, busy;

  io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .io_sel(io_sel), .io_wordaddr(io_wordaddr),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_rstrb(io_rstrb),
    .io_rdata(io_rdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     acc;
    longint     pop;
    logic [7:0] data;
  } frame_t;

  int          total = 0;
  int          bad = 0;
  longint      cyc = 0;
  frame_t      sched[$];
  frame_t      exp_tx[$];
  logic [31:0] exp_rd[$];
  logic        model_ovf = 1'b0;
  longint      last_end = 0;
  logic        rd_seen = 1'b0;
  logic [31:0] last_exp_rd = '0;
  logic        frame_active = 1'b0;
  longint      fstart = 0;
  logic [7:0]  rxb = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_seen <= !rst && io_sel && io_rstrb && io_wordaddr[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bytes sitting in the FIFO just before edge t.
  function automatic int count_at(longint t);
    int n = 0;
    foreach (sched[i]) if (sched[i].acc < t && sched[i].pop >= t) n++;
    return n;
  endfunction

  // Busy just after edge e: some accepted byte whose frame has not yet finished.
  function automatic bit busy_at(longint e);
    foreach (sched[i]) if (sched[i].acc <= e && sched[i].pop + 10 * C > e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic sel, input logic [29:0] wa, input logic ws,
                      input logic rs, input logic [7:0] d);
    longint t;
    int cnt;
    bit bsy, vw, vr, ovf_now;
    frame_t f;
    logic [31:0] st;
    @(posedge clk);
    #1;
    io_sel = sel; io_wordaddr = wa; io_wstrb = ws; io_rstrb = rs;
    io_wdata = $urandom();
    io_wdata[7:0] = d;
    t = cyc + 1;
    vw = sel && ws && wa[1];
    vr = sel && rs && wa[2];
    cnt = count_at(t);
    bsy = busy_at(t - 1);
    ovf_now = vw && (cnt == D);
    if (vr) begin
      st = 32'd0;
      st[0] = (cnt == D);
      st[1] = bsy;
      st[2] = !bsy;
      st[3] = model_ovf || ovf_now;
      exp_rd.push_back(st);
    end
    if (vw && !ovf_now) begin
      f.acc = t;
      f.pop = (t + 1 > last_end) ? t + 1 : last_end;
      f.data = d;
      sched.push_back(f);
      exp_tx.push_back(f);
      last_end = f.pop + 10 * C;
    end
    if (ovf_now) model_ovf = 1'b1;
    else if (vr) model_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 30'h0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, 30'h2, 1'b1, 1'b0, d);
  endtask

  task automatic rd_check(input string name, input logic [31:0] want);
    step(1'b1, 30'h4, 1'b0, 1'b1, 8'h00);
    step(1'b0, 30'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check(name, io_rdata, want);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    io_sel = 1'b0; io_wstrb = 1'b0; io_rstrb = 1'b0; io_wordaddr = '0;
    sched.delete(); exp_tx.delete(); exp_rd.delete();
    model_ovf = 1'b0;
    last_end = 0;
    @(posedge clk);
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rdata", io_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Read monitor and busy tracker.
  always @(negedge clk) begin
    if (rst) begin
      last_exp_rd = '0;
    end else begin
      if (rd_seen) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got %h want none", io_rdata);
        end else begin
          last_exp_rd = exp_rd.pop_front();
          check("status", io_rdata, last_exp_rd);
        end
      end else begin
        check("rdata_hold", io_rdata, last_exp_rd);
      end
      check("busy", {31'd0, busy}, {31'd0, busy_at(cyc)});
    end
  end

  // Serial receiver: samples mid-bit and checks byte value and frame start edge.
  always @(negedge clk) begin
    longint off;
    int idx;
    frame_t f;
    if (rst) begin
      frame_active = 1'b0;
    end else begin
      if (!frame_active && tx == 1'b0) begin
        frame_active = 1'b1;
        fstart = cyc;
      end
      if (frame_active) begin
        off = cyc - fstart;
        if (off % C == C / 2) begin
          idx = int'(off / C);
          if (idx == 0) check("start_bit", {31'd0, tx}, 32'd0);
          else if (idx <= 8) rxb[idx-1] = tx;
          else begin
            check("stop_bit", {31'd0, tx}, 32'd1);
            if (exp_tx.size() == 0) begin
              total++; bad++;
              $display("FAIL tx_unexpected: got frame %h want none", rxb);
            end else begin
              f = exp_tx.pop_front();
              check("tx_data", {24'd0, rxb}, {24'd0, f.data});
              check("tx_start", 32'(fstart), 32'(f.pop));
            end
          end
        end
        if (off == 10 * C - 1) frame_active = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_reset();
    rd_check("idle_status", 32'h4);

    wr(8'h55);
    idle(50);

    do_reset();
    for (int i = 1; i <= 6; i++) wr(8'(i));
    rd_check("ovf_status", 32'hB);
    rd_check("ovf_cleared", 32'h3);
    idle(220);

    step(1'b0, 30'h2, 1'b1, 1'b0, 8'hAA);
    step(1'b1, 30'h4, 1'b1, 1'b0, 8'hBB);
    rd_check("ignored_writes", 32'h4);
    idle(50);

    do_reset();
    for (int i = 0; i < 3; i++) wr(8'hC0 + 8'(i));
    idle(4 * C + 1);
    do_reset();
    rd_check("after_midframe_rst", 32'h4);
    idle(60);

    do_reset();
    for (int i = 1; i <= 5; i++) wr(8'h10 + 8'(i));
    step(1'b1, 30'h6, 1'b1, 1'b1, 8'h66);
    step(1'b0, 30'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("same_edge_ovf", io_rdata, 32'hB);
    rd_check("ovf_kept", 32'hB);
    rd_check("ovf_clear2", 32'h3);
    idle(220);

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      wr(8'($urandom()));
      else if (r < 22) step(1'b1, 30'h4, 1'b0, 1'b1, 8'h00);
      else if (r < 26) step(1'b0, 30'h2, 1'b1, 1'b0, 8'($urandom()));
      else if (r < 29) step(1'b1, 30'h4, 1'b1, 1'b0, 8'($urandom()));
      else if (r < 31) step(1'b1, 30'h8, 1'b1, 1'b1, 8'($urandom()));
      else             idle(1);
    end
    for (int k = 0; k < 3000 && cyc <= last_end + 4; k++) idle(1);
    idle(4);

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
